// File: rtl/messbauer_multi_side_test_environment_if.sv
// rtl/messbauer_multi_side_test_environment_if.sv - side control inputs and stimulus outputs bundle
//
// Purpose: groups the per-side control and stimulus signals of the test environment.
// Ports (signals):
//   side_enable          per-side run enable            (master -> slave)
//   side_mode            per-side waveform select       (master -> slave)
//   v_channel            channel-advance pulse          (slave -> master)
//   v_start              frame-start pulse              (slave -> master)
//   v_velocity_reference packed per-side reference      (slave -> master)
//   v_lower_threshold    lower-threshold test pulse     (slave -> master)
//   v_upper_threshold    upper-threshold test pulse     (slave -> master)
//   sequencer_busy       reset sequence not yet in RUN  (slave -> master)
interface messbauer_multi_side_test_environment_if #(
   parameter int SIDE_COUNT = 2,
   parameter int REF_WIDTH  = 12
);
   logic [SIDE_COUNT-1:0]           side_enable;
   logic [SIDE_COUNT-1:0]           side_mode;
   logic [SIDE_COUNT-1:0]           v_channel;
   logic [SIDE_COUNT-1:0]           v_start;
   logic [SIDE_COUNT*REF_WIDTH-1:0] v_velocity_reference;
   logic [SIDE_COUNT-1:0]           v_lower_threshold;
   logic [SIDE_COUNT-1:0]           v_upper_threshold;
   logic                            sequencer_busy;

   modport master (
      output side_enable, side_mode,
      input  v_channel, v_start, v_velocity_reference,
             v_lower_threshold, v_upper_threshold, sequencer_busy
   );

   modport slave (
      input  side_enable, side_mode,
      output v_channel, v_start, v_velocity_reference,
             v_lower_threshold, v_upper_threshold, sequencer_busy
   );
endinterface

// File: rtl/messbauer_multi_side_test_environment.sv
// rtl/messbauer_multi_side_test_environment.sv - multi-side Moessbauer velocity stimulus generator
//
// Purpose: reset sequencer (HOLD -> PULSE -> RUN) plus SIDE_COUNT independent
// channel/frame sequencers producing channel pulses, frame starts, a velocity
// reference (sawtooth, optionally triangle) and discriminator threshold test pulses.
// Ports:
//   global_clock  single clock
//   global_reset  synchronous active-high reset
//   env_if        slave modport: side_enable/side_mode in, stimulus outputs out
// Configuration macro: MESSBAUER_TEST_ENV_TRIANGLE_EN builds triangle mode;
// without it side_mode is ignored and every side produces sawtooth.
module messbauer_multi_side_test_environment #(
   parameter int SIDE_COUNT         = 2,
   parameter int CHANNEL_NUMBER     = 512,
   parameter int REF_WIDTH          = 12,
   parameter int CHANNEL_PERIOD     = 50,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int RESET_PULSE_CYCLES = 16
) (
   input logic                                    global_clock,
   input logic                                    global_reset,
   messbauer_multi_side_test_environment_if.slave env_if
);
   localparam int IW      = $clog2(CHANNEL_NUMBER);
   localparam int PW      = $clog2(CHANNEL_PERIOD);
   localparam int SHIFT   = REF_WIDTH - IW;
   localparam int SEQ_MAX = (RESET_HOLD_CYCLES > RESET_PULSE_CYCLES) ? RESET_HOLD_CYCLES : RESET_PULSE_CYCLES;
   localparam int CW      = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(RESET_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(RESET_PULSE_CYCLES - 1);
   localparam logic [PW-1:0] P_LAST     = PW'(CHANNEL_PERIOD - 1);

   logic [1:0]                           state_q, state_d;
   logic [CW-1:0]                        seq_cnt_q, seq_cnt_d;
   logic [SIDE_COUNT-1:0][PW-1:0]        period_q, period_d;
   logic [SIDE_COUNT-1:0][IW-1:0]        next_idx_q, next_idx_d;
   logic [SIDE_COUNT-1:0][REF_WIDTH-1:0] ref_q, ref_d;
   logic [SIDE_COUNT-1:0]                channel_q, channel_d;
   logic [SIDE_COUNT-1:0]                start_q, start_d;
   logic [SIDE_COUNT-1:0]                odd_q, odd_d;
   logic [SIDE_COUNT-1:0]                lower_q, lower_d;
   logic [SIDE_COUNT-1:0]                upper_q, upper_d;
   logic [SIDE_COUNT-1:0]                side_run;

   function automatic logic [REF_WIDTH-1:0] saw_ref(input logic [IW-1:0] idx);
      saw_ref = REF_WIDTH'(idx) << SHIFT;
   endfunction

`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
   // Waveform latched per frame so a mode change never bends a frame mid-way.
   logic [SIDE_COUNT-1:0] mode_q, mode_d;

   // Folding the upper half onto N-1-idx keeps the peak at (N-2)*SCALE, below full scale.
   function automatic logic [REF_WIDTH-1:0] tri_ref(input logic [IW-1:0] idx);
      logic [IW-1:0] fold;
      fold    = idx[IW-1] ? ~idx : idx;
      tri_ref = REF_WIDTH'(fold) << (SHIFT + 1);
   endfunction
`else
   logic unused_side_mode;
   assign unused_side_mode = ^env_if.side_mode;
`endif

   // Reset sequencer
   always_comb begin
      state_d   = state_q;
      seq_cnt_d = seq_cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (seq_cnt_q == HOLD_LAST) begin
               state_d   = ST_PULSE;
               seq_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + 1'b1;
            end
         end
         ST_PULSE: begin
            if (seq_cnt_q == PULSE_LAST) begin
               state_d   = ST_RUN;
               seq_cnt_d = '0;
            end else begin
               seq_cnt_d = seq_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = ST_RUN;
            seq_cnt_d = '0;
         end
      endcase
   end

   // Per-side sequencers; a side that is not running is cleared on the next edge,
   // which also makes disable win over a coincident channel pulse.
   always_comb begin
      period_d   = '0;
      next_idx_d = '0;
      ref_d      = '0;
      channel_d  = '0;
      start_d    = '0;
      odd_d      = '0;
      lower_d    = '0;
      upper_d    = '0;
      side_run   = '0;
`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
      mode_d     = '0;
`endif
      for (int k = 0; k < SIDE_COUNT; k++) begin
         side_run[k] = (state_q == ST_RUN) && env_if.side_enable[k];
         if (side_run[k]) begin
            lower_d[k]    = channel_q[k];
            upper_d[k]    = channel_q[k] & odd_q[k];
            ref_d[k]      = ref_q[k];
            odd_d[k]      = odd_q[k];
            next_idx_d[k] = next_idx_q[k];
`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
            mode_d[k]     = mode_q[k];
`endif
            if (period_q[k] == P_LAST) begin
               period_d[k]   = '0;
               channel_d[k]  = 1'b1;
               start_d[k]    = (next_idx_q[k] == '0);
               odd_d[k]      = next_idx_q[k][0];
               next_idx_d[k] = next_idx_q[k] + 1'b1;
`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
               if (next_idx_q[k] == '0)
                  mode_d[k] = env_if.side_mode[k];
               ref_d[k] = mode_d[k] ? tri_ref(next_idx_q[k]) : saw_ref(next_idx_q[k]);
`else
               ref_d[k] = saw_ref(next_idx_q[k]);
`endif
            end else begin
               period_d[k] = period_q[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge global_clock) begin
      if (global_reset) begin
         state_q    <= ST_HOLD;
         seq_cnt_q  <= '0;
         period_q   <= '0;
         next_idx_q <= '0;
         ref_q      <= '0;
         channel_q  <= '0;
         start_q    <= '0;
         odd_q      <= '0;
         lower_q    <= '0;
         upper_q    <= '0;
`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
         mode_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         seq_cnt_q  <= seq_cnt_d;
         period_q   <= period_d;
         next_idx_q <= next_idx_d;
         ref_q      <= ref_d;
         channel_q  <= channel_d;
         start_q    <= start_d;
         odd_q      <= odd_d;
         lower_q    <= lower_d;
         upper_q    <= upper_d;
`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
         mode_q     <= mode_d;
`endif
      end
   end

   assign env_if.v_channel            = channel_q;
   assign env_if.v_start              = start_q;
   assign env_if.v_velocity_reference = ref_q;
   assign env_if.v_lower_threshold    = lower_q;
   assign env_if.v_upper_threshold    = upper_q;
   assign env_if.sequencer_busy       = (state_q != ST_RUN);
endmodule

// File: tb/tb_messbauer_multi_side_test_environment.sv
// tb/tb_messbauer_multi_side_test_environment.sv - scoreboard bench for the multi-side test environment
module tb_messbauer_multi_side_test_environment;
   localparam int SC    = 2;
   localparam int CN    = 8;
   localparam int RW    = 12;
   localparam int CP    = 4;
   localparam int RH    = 4;
   localparam int RP    = 4;
   localparam int SCALE = (1 << RW) / CN;

   typedef struct {
      int stamp;
      int ref_v;
      bit start;
   } pulse_t;

   typedef struct {
      int stamp;
      bit upper;
   } thr_t;

   typedef struct {
      int stamp;
      bit busy;
      int ref_v[SC];
   } level_t;

   bit clk;
   bit global_reset;
   int cyc;
   int n_tests;
   int n_fail;

   pulse_t pulse_q[SC][$];
   thr_t   thr_q[SC][$];
   level_t level_q[$];

   // reference model state
   int age;
   int run_len[SC];
   bit pend[SC];
   int pend_idx[SC];
   int last_ref[SC];
   bit frame_mode[SC];

   messbauer_multi_side_test_environment_if #(.SIDE_COUNT(SC), .REF_WIDTH(RW)) env_if ();

   messbauer_multi_side_test_environment #(
      .SIDE_COUNT(SC), .CHANNEL_NUMBER(CN), .REF_WIDTH(RW), .CHANNEL_PERIOD(CP),
      .RESET_HOLD_CYCLES(RH), .RESET_PULSE_CYCLES(RP)
   ) dut (
      .global_clock(clk),
      .global_reset(global_reset),
      .env_if(env_if)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int ref_model(input int idx, input bit tri_mode);
      int r;
      r = idx * SCALE;
`ifdef MESSBAUER_TEST_ENV_TRIANGLE_EN
      if (tri_mode) r = (idx < CN / 2) ? idx * 2 * SCALE : (CN - 1 - idx) * 2 * SCALE;
`else
      if (tri_mode) r = idx * SCALE;
`endif
      return r;
   endfunction

   // Drive one cycle of inputs and push what the DUT must show in the following cycle.
   task automatic step(input bit rst, input bit [SC-1:0] en, input bit [SC-1:0] mode);
      bit     busy_now;
      bit     run_now;
      int     idx;
      level_t lv;
      pulse_t pe;
      thr_t   te;
      global_reset       = rst;
      env_if.side_enable = en;
      env_if.side_mode   = mode;
      busy_now = (age < RH + RP);
      lv.stamp = cyc + 1;
      lv.busy  = rst ? 1'b1 : (age + 1 < RH + RP);
      for (int k = 0; k < SC; k++) begin
         run_now = !rst && !busy_now && en[k];
         if (pend[k] && run_now) begin
            te.stamp = cyc + 1;
            te.upper = (pend_idx[k] % 2) == 1;
            thr_q[k].push_back(te);
         end
         pend[k] = 0;
         if (run_now) begin
            run_len[k]++;
            if (run_len[k] % CP == 0) begin
               idx = (run_len[k] / CP - 1) % CN;
               if (idx == 0) frame_mode[k] = mode[k];
               last_ref[k] = ref_model(idx, frame_mode[k]);
               pe.stamp = cyc + 1;
               pe.ref_v = last_ref[k];
               pe.start = (idx == 0);
               pulse_q[k].push_back(pe);
               pend[k]     = 1;
               pend_idx[k] = idx;
            end
         end else begin
            run_len[k]  = 0;
            last_ref[k] = 0;
         end
         lv.ref_v[k] = last_ref[k];
      end
      level_q.push_back(lv);
      age = rst ? 0 : ((age < 1000) ? age + 1 : age);
      @(posedge clk);
      #1;
   endtask

   // Monitor: levels are checked every cycle, pulses are popped when the DUT raises them.
   initial begin
      level_t lv;
      pulse_t pe;
      thr_t   te;
      forever begin
         @(negedge clk);
         if (level_q.size() > 0 && level_q[0].stamp == cyc) begin
            lv = level_q.pop_front();
            check("sequencer_busy", int'(env_if.sequencer_busy), int'(lv.busy));
            for (int k = 0; k < SC; k++)
               check($sformatf("reference_level_side%0d", k),
                     int'(env_if.v_velocity_reference[k*RW +: RW]), lv.ref_v[k]);
         end
         for (int k = 0; k < SC; k++) begin
            if (env_if.v_channel[k] === 1'b1) begin
               if (pulse_q[k].size() == 0) begin
                  check($sformatf("unexpected_channel_side%0d", k), 1, 0);
               end else begin
                  pe = pulse_q[k].pop_front();
                  check($sformatf("channel_cycle_side%0d", k), cyc, pe.stamp);
                  check($sformatf("channel_reference_side%0d", k),
                        int'(env_if.v_velocity_reference[k*RW +: RW]), pe.ref_v);
                  check($sformatf("start_side%0d", k), int'(env_if.v_start[k]), int'(pe.start));
               end
            end else if (env_if.v_start[k] === 1'b1) begin
               check($sformatf("start_without_channel_side%0d", k), 1, 0);
            end
            if (env_if.v_lower_threshold[k] === 1'b1) begin
               if (thr_q[k].size() == 0) begin
                  check($sformatf("unexpected_lower_side%0d", k), 1, 0);
               end else begin
                  te = thr_q[k].pop_front();
                  check($sformatf("lower_cycle_side%0d", k), cyc, te.stamp);
                  check($sformatf("upper_side%0d", k), int'(env_if.v_upper_threshold[k]), int'(te.upper));
               end
            end else if (env_if.v_upper_threshold[k] === 1'b1) begin
               check($sformatf("upper_without_lower_side%0d", k), 1, 0);
            end
         end
      end
   end

   initial begin
      bit [SC-1:0] en;
      bit [SC-1:0] mode;
      bit          rst;
      global_reset       = 1;
      env_if.side_enable = '0;
      env_if.side_mode   = '0;
      @(posedge clk);
      #1;
      repeat (3) step(1, 2'b00, 2'b00);
      // release with both sides enabled, sawtooth on both
      repeat (80) step(0, 2'b11, 2'b00);
      // triangle requested on side 1 mid-frame, takes effect at next frame start
      repeat (80) step(0, 2'b11, 2'b10);
      // side 1 dropped for three cycles, side 0 keeps running
      repeat (3) step(0, 2'b01, 2'b10);
      repeat (60) step(0, 2'b11, 2'b10);
      // one-cycle reset in the middle of RUN
      step(1, 2'b11, 2'b10);
      repeat (60) step(0, 2'b11, 2'b11);
      // randomized enables, modes and occasional resets
      en   = 2'b11;
      mode = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int j = 0; j < SC; j++)
            if ($urandom_range(0, 29) == 0) en[j] = ~en[j];
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         step(rst, en, mode);
      end
      repeat (6) step(0, 2'b00, 2'b00);
      @(negedge clk);
      @(negedge clk);
      check("level_queue_drained", level_q.size(), 0);
      for (int k = 0; k < SC; k++) begin
         check($sformatf("pulse_queue_drained_side%0d", k), pulse_q[k].size(), 0);
         check($sformatf("threshold_queue_drained_side%0d", k), thr_q[k].size(), 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
